// File: rtl/if_pkg.sv
// Shared constants for the instruction fetch stage: widths, reset PC,
// FSM state codes, the canonical NOP and the opcode slice helper.
package if_pkg;

  localparam int          IF_XLEN     = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  // Fetch FSM state codes
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [31:0] IF_NOP = 32'h0000_0013;

  // Opcode field consumed by the control unit
  localparam int OPC_LSB = 2;
  localparam int OPC_MSB = 6;

  function automatic logic [4:0] opcode_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Parametric depth-N FIFO with synchronous flush. Used for the returned
// {data,pc} instruction buffer and for the in-flight PC tag queue.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  assign empty     = (count_r == '0);
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage write; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  if_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .full  (full)
  );

endmodule

// Overflow checker: the issue rule must keep every queue from overflowing.
module if_fifo_chk (
  input logic clk,
  input logic rst,
  input logic flush,
  input logic push,
  input logic full
);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !flush))
    else $error("if_fifo: push while full");
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches, buffers up to
// MAX_OUTSTANDING returned words and hands them to decode. Branch redirects
// discard buffered and in-flight fetches.
// Optional macro IF_ILLEGAL_CHECK_EN enables the inst_illegal flag.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int              XLEN            = IF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(IF_RESET_PC),
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [4:0]      inst_opcode,
  output logic            inst_illegal
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int EW = 32 + XLEN;

  logic [1:0]      state_r, state_n;
  logic [XLEN-1:0] pc_r, pc_n;
  logic [CW-1:0]   outstanding_r, outstanding_n;
  logic [CW-1:0]   drop_cnt_r, drop_cnt_n;

  logic            redir_s;
  logic            rsp_s;
  logic            keep_s;
  logic            hs_s;
  logic [CW:0]     occ_s;
  logic [CW-1:0]   out_after_rsp_s;

  logic [EW-1:0]   inst_head_s;
  logic            inst_empty_s, inst_full_s;
  logic [CW-1:0]   inst_count_s;
  logic [XLEN-1:0] tag_head_s;
  logic            tag_empty_s, tag_full_s;
  logic [CW-1:0]   tag_count_s;
  logic            unused_s;

  assign redir_s         = redirect_valid && (state_r != ST_BOOT);
  assign rsp_s           = imem_rsp_valid && (outstanding_r != '0);
  assign keep_s          = rsp_s && (drop_cnt_r == '0);
  assign out_after_rsp_s = outstanding_r - CW'(rsp_s);
  assign occ_s           = {1'b0, outstanding_r} + {1'b0, inst_count_s};

  assign imem_req_valid  = (state_r == ST_RUN) && (occ_s < (CW+1)'(MAX_OUTSTANDING)) && !redir_s;
  assign imem_req_addr   = {pc_r[XLEN-1:2], 2'b00};
  assign hs_s            = imem_req_valid && imem_req_ready;

  assign inst_valid  = !inst_empty_s;
  assign inst_data   = inst_valid ? inst_head_s[EW-1:XLEN] : 32'h0;
  assign inst_pc     = inst_valid ? inst_head_s[XLEN-1:0] : '0;
  assign inst_opcode = opcode_of(inst_data);

`ifdef IF_ILLEGAL_CHECK_EN
  assign inst_illegal = inst_valid && ((inst_data[1:0] != 2'b11) || (inst_data == 32'h0));
`else
  assign inst_illegal = 1'b0;
`endif

  assign unused_s = ^{redirect_pc[1:0], inst_full_s, tag_full_s, tag_count_s};

  // Returned instructions with their PCs; a redirect wipes them
  if_fifo #(.DEPTH(MAX_OUTSTANDING), .W(EW)) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redir_s),
    .push      (keep_s),
    .push_data ({imem_rsp_data, tag_head_s}),
    .pop       (inst_valid && inst_ready && !redir_s),
    .pop_data  (inst_head_s),
    .empty     (inst_empty_s),
    .full      (inst_full_s),
    .count     (inst_count_s)
  );

  // Addresses of live in-flight requests, in issue order
  if_fifo #(.DEPTH(MAX_OUTSTANDING), .W(XLEN)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redir_s),
    .push      (hs_s),
    .push_data (imem_req_addr),
    .pop       (rsp_s && !tag_empty_s),
    .pop_data  (tag_head_s),
    .empty     (tag_empty_s),
    .full      (tag_full_s),
    .count     (tag_count_s)
  );

  // Next-state: PC advance, outstanding/drop accounting and redirect handling
  always_comb begin
    state_n       = state_r;
    pc_n          = pc_r;
    outstanding_n = outstanding_r;
    drop_cnt_n    = drop_cnt_r;
    case (state_r)
      ST_BOOT: begin
        state_n = ST_RUN;
      end
      ST_RUN, ST_FLUSH: begin
        outstanding_n = out_after_rsp_s + CW'(hs_s);
        if (redir_s) begin
          // Everything still in flight is now stale and must be dropped
          pc_n       = {redirect_pc[XLEN-1:2], 2'b00};
          drop_cnt_n = out_after_rsp_s;
          state_n    = (out_after_rsp_s != '0) ? ST_FLUSH : ST_RUN;
        end else begin
          if (hs_s) pc_n = pc_r + XLEN'(4);
          else      pc_n = pc_r;
          if (rsp_s && (drop_cnt_r != '0)) drop_cnt_n = drop_cnt_r - CW'(1);
          else                             drop_cnt_n = drop_cnt_r;
          state_n = (drop_cnt_n != '0) ? ST_FLUSH : ST_RUN;
        end
      end
      default: begin
        state_n = ST_BOOT;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_PC;
      outstanding_r <= '0;
      drop_cnt_r    <= '0;
    end else begin
      state_r       <= state_n;
      pc_r          <= pc_n;
      outstanding_r <= outstanding_n;
      drop_cnt_r    <= drop_cnt_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized self-checking bench for if_fetch_stage. The reference model
// tracks in-flight requests as a queue of {addr, stale} entries and the
// decode buffer as a queue of {data, pc}.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic [4:0]  inst_opcode;
  logic        inst_illegal;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_opcode    (inst_opcode),
    .inst_illegal   (inst_illegal)
  );

  typedef struct packed {logic [31:0] data; logic [31:0] pc;} ent_t;
  typedef struct {logic [31:0] addr; int due; bit stale;} mreq_t;

  ent_t        m_fifo[$];
  mreq_t       mq[$];
  bit          m_boot;
  logic [31:0] m_pc;
  int          cyc, last_due, lat_lo, lat_hi;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    logic [3:0]  s;
    s = a[5:2];
    case (s)
      4'd0:    r = 32'h0000_0033;
      4'd3:    r = 32'h0000_0000;
      4'd5:    r = 32'h0000_0013;
      default: r = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
    return r;
  endfunction

  function automatic logic exp_illegal(input logic [31:0] d);
`ifdef IF_ILLEGAL_CHECK_EN
    return (d[1:0] != 2'b11) || (d == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check_eq("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("rst_inst_data", inst_data, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    rst = 1'b0;
    m_fifo.delete(); mq.delete();
    m_boot = 1'b1; m_pc = 32'h0; last_due = cyc;
  endtask

  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc, input bit irdy);
    bit          rsp, exp_req, ev, flushing, pop;
    ent_t        head;
    mreq_t       e;
    logic [31:0] d;
    int          due;
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_req_ready = rdy; redirect_valid = redir; redirect_pc = rpc; inst_ready = irdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom;
    #4;
    flushing = 1'b0;
    foreach (mq[i]) if (mq[i].stale) flushing = 1'b1;
    exp_req = !m_boot && !flushing && (mq.size() + m_fifo.size() < 2) && !redir;
    check_eq("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    if (exp_req) check_eq("req_addr", imem_req_addr, m_pc);
    ev = (m_fifo.size() > 0);
    check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, ev});
    if (ev) head = m_fifo[0];
    else    head = '0;
    d = head.data;
    check_eq("inst_data", inst_data, d);
    check_eq("inst_pc", inst_pc, head.pc);
    check_eq("inst_opcode", {27'b0, inst_opcode}, {27'b0, d[6:2]});
    check_eq("inst_illegal", {31'b0, inst_illegal}, {31'b0, ev && exp_illegal(d)});
    @(posedge clk); #1;
    if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      pop = ev && irdy && !redir;
      if (pop) void'(m_fifo.pop_front());
      if (rsp) begin
        e = mq.pop_front();
        if (!e.stale) m_fifo.push_back({mem_word(e.addr), e.addr});
      end
      if (redir) begin
        m_fifo.delete();
        foreach (mq[i]) mq[i].stale = 1'b1;
        m_pc = {rpc[31:2], 2'b00};
      end else if (exp_req && rdy) begin
        due = cyc + $urandom_range(lat_hi, lat_lo);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{addr: m_pc, due: due, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    cyc = 0; lat_lo = 1; lat_hi = 1;
    do_reset();
    // Streaming with single-cycle memory and an always-ready decoder
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    // Decoder stalls: buffer fills and issue stops
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    // Slow memory so two requests are in flight, then redirect
    lat_lo = 3; lat_hi = 3;
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h100, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    lat_lo = 1; lat_hi = 2;
    // Unaligned redirect target and back-to-back redirects
    cycle(1'b1, 1'b1, 32'h203, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h40, 1'b1);
    cycle(1'b1, 1'b1, 32'h80, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    // PC wrap at the top of the address space
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    // Reset mid-operation (environment drops late responses)
    do_reset();
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle($urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0, rpc, $urandom_range(3, 0) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
